// File: rtl/fir_job_scheduler.sv
// rtl/fir_job_scheduler.sv - FIR job queue and single-engine dispatcher with cycle measurement
module fir_job_scheduler #(
  parameter int QDEPTH  = 4,
  parameter int ADDR_W  = 10,
  parameter int CYC_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic                     job_sel,
  input  logic [ADDR_W-1:0]        job_in_addr,
  input  logic [ADDR_W-1:0]        job_out_addr,
  input  logic [ADDR_W-1:0]        job_count,
  output logic                     eng_start,
  output logic                     eng_sel,
  output logic [ADDR_W-1:0]        eng_in_addr,
  output logic [ADDR_W-1:0]        eng_out_addr,
  output logic [ADDR_W-1:0]        eng_count,
  input  logic                     eng_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_id,
  output logic                     res_sel,
  output logic [CYC_W-1:0]         res_cycles,
  output logic                     res_timeout,
  output logic                     busy,
  output logic [$clog2(QDEPTH):0]  q_level
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;
  state_t state;

  logic              q_sel      [QDEPTH];
  logic [ADDR_W-1:0] q_in_addr  [QDEPTH];
  logic [ADDR_W-1:0] q_out_addr [QDEPTH];
  logic [ADDR_W-1:0] q_count    [QDEPTH];
  logic [3:0]        q_id       [QDEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [3:0]       id_cnt, cur_id;
  logic [CYC_W-1:0] cnt;
  logic             push, pop;

  assign job_ready = (q_level < LVL_W'(QDEPTH));
  assign push      = job_valid && job_ready;
  assign pop       = (state == IDLE) && (q_level != '0);
  assign busy      = (state != IDLE) || (q_level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_sel[wr_ptr]      <= job_sel;
      q_in_addr[wr_ptr]  <= job_in_addr;
      q_out_addr[wr_ptr] <= job_out_addr;
      q_count[wr_ptr]    <= job_count;
      q_id[wr_ptr]       <= id_cnt;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
      id_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        id_cnt <= id_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      q_level <= q_level + 1'b1;
      else if (pop && !push) q_level <= q_level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      eng_start    <= 1'b0;
      eng_sel      <= 1'b0;
      eng_in_addr  <= '0;
      eng_out_addr <= '0;
      eng_count    <= '0;
      res_valid    <= 1'b0;
      res_id       <= '0;
      res_sel      <= 1'b0;
      res_cycles   <= '0;
      res_timeout  <= 1'b0;
      cur_id       <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            eng_sel      <= q_sel[rd_ptr];
            eng_in_addr  <= q_in_addr[rd_ptr];
            eng_out_addr <= q_out_addr[rd_ptr];
            eng_count    <= q_count[rd_ptr];
            cur_id       <= q_id[rd_ptr];
            if (q_count[rd_ptr] == '0) begin
              res_id      <= q_id[rd_ptr];
              res_sel     <= q_sel[rd_ptr];
              res_cycles  <= '0;
              res_timeout <= 1'b0;
              res_valid   <= 1'b1;
              state       <= REPORT;
            end else begin
              eng_start <= !eng_done;
              state     <= LAUNCH;
            end
          end
        end
        // Start is withheld while a stale done is still high from the last job.
        LAUNCH: begin
          if (eng_start) begin
            eng_start <= 1'b0;
            cnt       <= '0;
            state     <= RUN;
          end else if (!eng_done) begin
            eng_start <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (eng_done) begin
            res_id      <= cur_id;
            res_sel     <= eng_sel;
            res_cycles  <= cnt + 1'b1;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= REPORT;
          end else if (cnt + 1'b1 == CYC_W'(TIMEOUT)) begin
            res_id      <= cur_id;
            res_sel     <= eng_sel;
            res_cycles  <= CYC_W'(TIMEOUT);
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_job_scheduler.sv
// tb/tb_fir_job_scheduler.sv - self-checking bench for fir_job_scheduler
module tb_fir_job_scheduler;
  localparam int TO = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic        job_sel = 1'b0;
  logic [9:0]  job_in_addr = '0;
  logic [9:0]  job_out_addr = '0;
  logic [9:0]  job_count = '0;
  logic        eng_start, eng_sel;
  logic [9:0]  eng_in_addr, eng_out_addr, eng_count;
  logic        eng_done = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  res_id;
  logic        res_sel;
  logic [31:0] res_cycles;
  logic        res_timeout, busy;
  logic [2:0]  q_level;
  logic [74:0] all_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       sel;
    bit [9:0] ia;
    bit [9:0] oa;
    bit [9:0] cnt;
    bit [3:0] id;
  } job_t;
  job_t mq[$];
  int   next_id = 0;

  fir_job_scheduler #(.QDEPTH(4), .ADDR_W(10), .CYC_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_sel(job_sel),
    .job_in_addr(job_in_addr), .job_out_addr(job_out_addr), .job_count(job_count),
    .eng_start(eng_start), .eng_sel(eng_sel), .eng_in_addr(eng_in_addr),
    .eng_out_addr(eng_out_addr), .eng_count(eng_count), .eng_done(eng_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sel(res_sel),
    .res_cycles(res_cycles), .res_timeout(res_timeout), .busy(busy), .q_level(q_level)
  );

  assign all_out = {eng_start, eng_sel, eng_in_addr, eng_out_addr, eng_count, res_valid,
                    res_id, res_sel, res_cycles, res_timeout, busy, q_level};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input bit s, input bit [9:0] ia, oa, cnt);
    job_t j;
    j.sel = s; j.ia = ia; j.oa = oa; j.cnt = cnt; j.id = 4'(next_id);
    next_id = (next_id + 1) % 16;
    mq.push_back(j);
  endtask

  task automatic push_job(input bit s, input bit [9:0] ia, oa, cnt, output bit ok);
    job_sel = s; job_in_addr = ia; job_out_addr = oa; job_count = cnt;
    job_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = job_ready;
      step();
    end
    job_valid = 1'b0;
    if (ok) model_push(s, ia, oa, cnt);
  endtask

  task automatic wait_start(input int lim, output bit seen);
    seen = eng_start;
    for (int i = 0; i < lim && !seen; i++) begin
      step();
      seen = eng_start;
    end
  endtask

  task automatic wait_res(input int lim, output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < lim) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst = 1'b1;
    step();
    checks++;
    if (job_ready !== 1'b1 || q_level !== 3'd0) begin
      errors++; $display("FAIL reset_ready: job_ready=%b q_level=%0d want 1/0", job_ready, q_level);
    end
  endtask

  task automatic test_single();
    job_t e; bit ok, seen; int extra;
    extra = 0;
    res_ready = 1'b1;
    push_job(1'b0, 10'd0, 10'd512, 10'd100, ok);
    e = mq[0];
    wait_start(10, seen);
    checks++;
    if (!ok || !seen) begin
      errors++; $display("FAIL single_start: accepted=%b start_seen=%b want 1/1", ok, seen);
    end
    checks++;
    if (eng_count !== e.cnt || eng_out_addr !== e.oa || eng_in_addr !== e.ia || eng_sel !== e.sel) begin
      errors++; $display("FAIL single_eng_fields: got cnt=%0d out=%0d in=%0d sel=%b want %0d/%0d/%0d/%b",
                         eng_count, eng_out_addr, eng_in_addr, eng_sel, e.cnt, e.oa, e.ia, e.sel);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (eng_start) extra++;
    end
    eng_done = 1'b1; step(); eng_done = 1'b0;
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL single_one_pulse: extra starts=%0d want 0", extra);
    end
    checks++;
    if (res_valid !== 1'b1 || res_cycles !== 32'd40 || res_id !== e.id || res_timeout !== 1'b0 || res_sel !== e.sel) begin
      errors++; $display("FAIL single_result: valid=%b cycles=%0d id=%0d to=%b sel=%b want 1/40/%0d/0/%b",
                         res_valid, res_cycles, res_id, res_timeout, res_sel, e.id, e.sel);
    end
    void'(mq.pop_front());
    step();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_handshake: valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    job_t e; bit ok; int bad; bit [9:0] f_ia, f_oa;
    bad = 0;
    res_ready = 1'b0;
    push_job(1'b1, 10'd5, 10'd6, 10'd0, ok);
    checks++;
    if (eng_start !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL zero_count_early: start=%b valid=%b want 0/0", eng_start, res_valid);
    end
    step();
    checks++;
    if (!ok || res_valid !== 1'b1 || res_cycles !== 32'd0 || res_id !== mq[0].id || eng_start !== 1'b0) begin
      errors++; $display("FAIL zero_count_result: valid=%b cycles=%0d id=%0d start=%b want 1/0/%0d/0",
                         res_valid, res_cycles, res_id, eng_start, mq[0].id);
    end
    for (int i = 0; i < 4; i++)
      push_job(1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom), 10'($urandom_range(1, 1023)), ok);
    checks++;
    if (q_level !== 3'd4 || job_ready !== 1'b0) begin
      errors++; $display("FAIL full_level: q_level=%0d job_ready=%b want 4/0", q_level, job_ready);
    end
    f_ia = 10'($urandom); f_oa = 10'($urandom);
    job_sel = 1'b0; job_in_addr = f_ia; job_out_addr = f_oa; job_count = 10'd7; job_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (job_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0 || q_level !== 3'd4 || res_valid !== 1'b1) begin
      errors++; $display("FAIL held_off: ready_highs=%0d q_level=%0d valid=%b want 0/4/1", bad, q_level, res_valid);
    end
    res_ready = 1'b1;
    step();
    void'(mq.pop_front());
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b0) begin
      errors++; $display("FAIL stall_release: valid=%b job_ready=%b want 0/0", res_valid, job_ready);
    end
    step();
    e = mq[0];
    checks++;
    if (q_level !== 3'd3 || job_ready !== 1'b1 || eng_start !== 1'b1) begin
      errors++; $display("FAIL first_pop: q_level=%0d job_ready=%b start=%b want 3/1/1", q_level, job_ready, eng_start);
    end
    checks++;
    if (eng_sel !== e.sel || eng_in_addr !== e.ia || eng_out_addr !== e.oa || eng_count !== e.cnt) begin
      errors++; $display("FAIL pop_fields: got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                         eng_sel, eng_in_addr, eng_out_addr, eng_count, e.sel, e.ia, e.oa, e.cnt);
    end
    step();
    job_valid = 1'b0;
    model_push(1'b0, f_ia, f_oa, 10'd7);
    checks++;
    if (q_level !== 3'd4) begin
      errors++; $display("FAIL fifth_accept: q_level=%0d want 4", q_level);
    end
  endtask

  task automatic test_timeout();
    job_t e; int n;
    e = mq[0];
    wait_res(TO + 20, n);
    checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_cycles !== 32'(TO) || res_id !== e.id || n != TO) begin
      errors++; $display("FAIL timeout_result: valid=%b to=%b cycles=%0d id=%0d wait=%0d want 1/1/%0d/%0d/%0d",
                         res_valid, res_timeout, res_cycles, res_id, n, TO, e.id, TO);
    end
    void'(mq.pop_front());
    e = mq[0];
    step(); step();
    checks++;
    if (eng_start !== 1'b1 || eng_in_addr !== e.ia || eng_count !== e.cnt) begin
      errors++; $display("FAIL after_timeout_launch: start=%b in=%0d cnt=%0d want 1/%0d/%0d",
                         eng_start, eng_in_addr, eng_count, e.ia, e.cnt);
    end
    repeat (5) step();
    eng_done = 1'b1; step(); eng_done = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_cycles !== 32'd5 || res_id !== e.id) begin
      errors++; $display("FAIL after_timeout_result: valid=%b to=%b cycles=%0d id=%0d want 1/0/5/%0d",
                         res_valid, res_timeout, res_cycles, res_id, e.id);
    end
    void'(mq.pop_front());
  endtask

  task automatic test_reset_mid_run();
    bit seen, ok; int bad;
    bad = 0;
    wait_start(10, seen);
    repeat (3) step();
    checks++;
    if (!seen || q_level !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_setup: seen=%b q_level=%0d busy=%b want 1/2/1", seen, q_level, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL midrun_async: got %h want 0", all_out);
    end
    step();
    rst = 1'b1;
    mq.delete();
    next_id = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (res_valid !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midrun_quiet: active cycles=%0d want 0", bad);
    end
    push_job(1'b1, 10'd100, 10'd200, 10'd3, ok);
    wait_start(10, seen);
    repeat (2) step();
    eng_done = 1'b1; step(); eng_done = 1'b0;
    checks++;
    if (!ok || !seen || res_valid !== 1'b1 || res_id !== mq[0].id || res_cycles !== 32'd2 || res_sel !== 1'b1) begin
      errors++; $display("FAIL post_reset_id: valid=%b id=%0d cycles=%0d sel=%b want 1/%0d/2/1",
                         res_valid, res_id, res_cycles, res_sel, mq[0].id);
    end
    void'(mq.pop_front());
    step();
  endtask

  task automatic test_random();
    job_t e; bit ok, seen, exp_to; int lat, rd, n, k; bit [31:0] exp_c;
    res_ready = 1'b0;
    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(1, 2);
      for (int p = 0; p < k; p++) begin
        push_job(1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
                 ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)), ok);
        checks++;
        if (!ok) begin
          errors++; $display("FAIL rand_push: accepted=0 want 1");
        end
      end
      for (int p = 0; p < k && mq.size() > 0; p++) begin
        e = mq.pop_front();
        lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
        rd = $urandom_range(0, 3);
        exp_to = (e.cnt != 0) && (lat == 0);
        exp_c = (e.cnt == 0) ? 32'd0 : (lat == 0) ? 32'(TO) : 32'(lat);
        if (e.cnt != 0) begin
          wait_start(20, seen);
          checks++;
          if (!seen || eng_sel !== e.sel || eng_in_addr !== e.ia || eng_out_addr !== e.oa || eng_count !== e.cnt) begin
            errors++; $display("FAIL rand_launch: seen=%b got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", seen,
                               eng_sel, eng_in_addr, eng_out_addr, eng_count, e.sel, e.ia, e.oa, e.cnt);
          end
          if (lat > 0) begin
            repeat (lat) step();
            eng_done = 1'b1; step(); eng_done = 1'b0;
          end
        end
        wait_res(TO + 20, n);
        checks++;
        if (res_valid !== 1'b1 || res_id !== e.id || res_sel !== e.sel || res_cycles !== exp_c || res_timeout !== exp_to) begin
          errors++; $display("FAIL rand_result: valid=%b id=%0d sel=%b cycles=%0d to=%b want 1/%0d/%b/%0d/%b",
                             res_valid, res_id, res_sel, res_cycles, res_timeout, e.id, e.sel, exp_c, exp_to);
        end
        repeat (rd) step();
        checks++;
        if (res_valid !== 1'b1 || res_id !== e.id || res_cycles !== exp_c) begin
          errors++; $display("FAIL rand_hold: valid=%b id=%0d cycles=%0d want 1/%0d/%0d", res_valid, res_id, res_cycles, e.id, exp_c);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
          errors++; $display("FAIL rand_handshake: valid=%b want 0", res_valid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_job_scheduler.md
Name: fir_job_scheduler

Overview:
- Queues FIR filter jobs from the host and dispatches them one at a time to the shared FIR engine pair (non-pipelined / pipelined) inside fir_top.
- Each job carries: engine select, input base address, output base address, sample count.
- Drives the engine start/select/address/count inputs and waits for engine done.
- Measures run cycles per job and returns a result record to the host through a valid/ready result port.
- Sits between the host/control logic and fir_top's start/done interface, replacing hand-sequenced start pulses.

Parameters:
- QDEPTH, 4: job queue entries; power of two, at least 2.
- ADDR_W, 10: address and count width; matches the 1024-entry shared memory.
- CYC_W, 32: cycle counter width.
- TIMEOUT, 65535: RUN-state cycle limit before the job is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- job_valid  in  1  host offers a job.
- job_ready  out  1  queue can accept a job.
- job_sel  in  1  0 = non-pipelined engine, 1 = pipelined engine.
- job_in_addr  in  ADDR_W  input sample base address.
- job_out_addr  in  ADDR_W  output base address.
- job_count  in  ADDR_W  number of samples.
- eng_start  out  1  one-cycle start pulse to fir_top.
- eng_sel  out  1  registered engine select.
- eng_in_addr  out  ADDR_W  registered input base address.
- eng_out_addr  out  ADDR_W  registered output base address.
- eng_count  out  ADDR_W  registered sample count.
- eng_done  in  1  engine completion, level or pulse.
- res_valid  out  1  result record available.
- res_ready  in  1  host accepts the result.
- res_id  out  4  job sequence number.
- res_sel  out  1  engine that ran the job.
- res_cycles  out  CYC_W  measured run cycles.
- res_timeout  out  1  job was aborted by timeout.
- busy  out  1  FSM is not in IDLE, or the queue is non-empty.
- q_level  out  log2(QDEPTH)+1  queue occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; queue is emptied; job id counter clears to 0.
  - eng_start, res_valid, res_timeout and busy are 0.
  - All eng_* and res_* data outputs are 0.
  - q_level is 0; job_ready is 1 after reset is released.
- Reset mid-RUN: the job is discarded and no result is produced. The engine itself is reset by its own rst.
- Queue:
  - A job is accepted on any edge where job_valid and job_ready are both high.
  - job_ready = (q_level < QDEPTH), combinational.
  - The accepted job is tagged with the id counter value; the counter then increments and wraps 15 to 0.
  - A push and a pop in the same cycle are both performed; q_level is unchanged and a full queue stays full.
  - Circular read/write pointers wrap at QDEPTH.
- FSM states: IDLE, LAUNCH, RUN, REPORT.
- IDLE:
  - If the queue is non-empty, pop the head into the eng_* and job registers.
  - If the popped count == 0, go to REPORT with res_cycles = 0 and no eng_start.
  - Otherwise go to LAUNCH.
  - The earliest dispatch is the edge after a job is accepted into an empty queue.
- LAUNCH: eng_start = 1 for exactly this one cycle; cycle counter cleared to 0; go to RUN.
- RUN:
  - The counter increments every cycle.
  - If eng_done is high: res_cycles = counter + 1 (RUN cycles including the done cycle), res_timeout = 0, go to REPORT.
  - Else if counter + 1 == TIMEOUT: res_cycles = TIMEOUT, res_timeout = 1, go to REPORT.
  - eng_done == 1 in the first RUN cycle gives res_cycles = 1.
  - eng_done outside RUN is ignored; a done still high from a previous job does not complete the next job.
  - A job must not launch while eng_done is high: LAUNCH is held until eng_done is low.
- REPORT:
  - res_valid = 1; res_id, res_sel, res_cycles and res_timeout are held stable.
  - On the edge where res_ready is high, res_valid falls and the FSM goes to IDLE.
  - Back-pressure (res_ready low) stalls dispatch indefinitely; the queue still accepts jobs.
- eng_* data outputs keep their last job's values until the next pop.
- res_cycles saturates at TIMEOUT and never wraps.
- Minimum overhead per job: one IDLE cycle, one LAUNCH cycle, and one REPORT cycle when res_ready is already high.

Test Plan:
- Single job (sel=0, in=0, out=512, count=100); the engine model asserts done 40 cycles after start, res_ready held high.
  -> Exactly one eng_start pulse, eng_count=100, res_valid with res_cycles=40, res_id=0, res_timeout=0.
- Push 5 jobs back-to-back with no dispatch progress (engine never done).
  -> job_ready falls after the 4th accept (q_level=4), the 5th job is held off, and it is accepted the cycle after the first pop.
- Jobs sel=0 then sel=1 with out=512 and 612, res_ready held low for 10 cycles on the first result.
  -> The second eng_start is not issued until the first result handshakes; res_sel order is 0, 1; res_id order is 0, 1.
- Job with count=0.
  -> No eng_start; res_valid asserted with res_cycles=0 two cycles after accept.
- TIMEOUT=20, engine never asserts done.
  -> res_timeout=1, res_cycles=20, the FSM returns to IDLE, and the next queued job launches normally.
- Assert rst low for 1 cycle mid-RUN with 2 jobs queued.
  -> All outputs are 0 immediately, q_level=0, no res_valid for the aborted jobs, and the next accepted job gets res_id=0.
